iir_m_feeder: RTL and testbench

Sample-stream controller that drives the `IIR_m` filter's request-paced input port and collects its output. It buffers upstream 12-bit samples in a small FIFO, primes the filter with the first sample on `start`, and issues each further sample one cycle after the filter's `dout_prevalid` request. It forwards filtered 18-bit results downstream and signals completion after `FRAME_LEN` outputs. It sits between the sample source (ADC/DMA) and `IIR_m` and replaces the bench-side feeder in synthesizable form.

---
 rtl/iir_m_feeder_if.sv | 36 +++
 rtl/iir_m_feeder.sv | 164 ++++++++++++++++
 tb/tb_iir_m_feeder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_m_feeder_if.sv
// Bus bundle between the IIR_m sample feeder, its upstream sample source,
// the filter's request-paced ports and the downstream result sink.
interface iir_m_feeder_if #(
  parameter int DIN_W  = 12,
  parameter int DOUT_W = 18,
  parameter int CNT_W  = 16
);
  logic signed [DIN_W-1:0]  s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     start;
  logic signed [DIN_W-1:0]  flt_din;
  logic                     flt_din_valid;
  logic                     flt_dout_prevalid;
  logic signed [DOUT_W-1:0] flt_dout;
  logic                     flt_dout_valid;
  logic signed [DOUT_W-1:0] m_data;
  logic                     m_valid;
  logic                     busy;
  logic                     done;
  logic                     underrun;
  logic [CNT_W-1:0]         in_cnt;
  logic [CNT_W-1:0]         out_cnt;

  modport master (
    input  s_data, s_valid, start, flt_dout_prevalid, flt_dout, flt_dout_valid,
    output s_ready, flt_din, flt_din_valid, m_data, m_valid, busy, done,
           underrun, in_cnt, out_cnt
  );

  modport slave (
    output s_data, s_valid, start, flt_dout_prevalid, flt_dout, flt_dout_valid,
    input  s_ready, flt_din, flt_din_valid, m_data, m_valid, busy, done,
           underrun, in_cnt, out_cnt
  );
endinterface

// File: rtl/iir_m_feeder.sv
// Request-paced feeder for IIR_m: buffers upstream samples, issues one sample
// per filter request, forwards results and reports frame completion.
module iir_m_feeder #(
  parameter int DIN_W      = 12,
  parameter int DOUT_W     = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 40000,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  iir_m_feeder_if.master bus
);
  localparam int               AW          = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam bit               ONE_SHOT    = (FRAME_LEN == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_WAIT_REQ, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DIN_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]              wr_ptr_q, rd_ptr_q;
  logic                     fifo_empty, fifo_full, push, pop;
  logic signed [DIN_W-1:0]  fifo_head;

  logic signed [DIN_W-1:0]  flt_din_q, flt_din_d;
  logic                     flt_din_valid_q, flt_din_valid_d;
  logic signed [DOUT_W-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     underrun_q, underrun_d;
  logic [CNT_W-1:0]         in_cnt_q, in_cnt_d, in_cnt_inc;
  logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = bus.s_valid && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
  assign in_cnt_inc = in_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    flt_din_d       = flt_din_q;
    flt_din_valid_d = 1'b0;
    m_data_d        = m_data_q;
    m_valid_d       = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    underrun_d      = underrun_q;
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          underrun_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_PRIME;
        end
      end
      S_PRIME: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          flt_din_d       = fifo_head;
          flt_din_valid_d = 1'b1;
          in_cnt_d        = CNT_W'(1);
          state_d         = ONE_SHOT ? S_DRAIN : S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: begin
        if (bus.flt_dout_prevalid) begin
          state_d = S_ISSUE;
          if (fifo_empty) underrun_d = 1'b1;
        end
      end
      // A request that found the FIFO empty stays pending here until data lands.
      S_ISSUE: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          flt_din_d       = fifo_head;
          flt_din_valid_d = 1'b1;
          in_cnt_d        = in_cnt_inc;
          state_d         = (in_cnt_inc == FRAME_LEN_C) ? S_DRAIN : S_WAIT_REQ;
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == FRAME_LEN_C) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Results are only counted inside a frame and never beyond its length.
    if (bus.flt_dout_valid && busy_q && (out_cnt_q != FRAME_LEN_C)) begin
      m_data_d  = bus.flt_dout;
      m_valid_d = 1'b1;
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      flt_din_q       <= '0;
      flt_din_valid_q <= 1'b0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      underrun_q      <= 1'b0;
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      flt_din_q       <= flt_din_d;
      flt_din_valid_q <= flt_din_valid_d;
      m_data_q        <= m_data_d;
      m_valid_q       <= m_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      underrun_q      <= underrun_d;
      in_cnt_q        <= in_cnt_d;
      out_cnt_q       <= out_cnt_d;
    end
  end

  assign bus.s_ready       = !fifo_full;
  assign bus.flt_din       = flt_din_q;
  assign bus.flt_din_valid = flt_din_valid_q;
  assign bus.m_data        = m_data_q;
  assign bus.m_valid       = m_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.underrun      = underrun_q;
  assign bus.in_cnt        = in_cnt_q;
  assign bus.out_cnt       = out_cnt_q;
endmodule

// File: tb/tb_iir_m_feeder.sv
// Bench for iir_m_feeder: an emulated filter (result = din*64) answers each
// issued sample with a request; a queue model predicts samples and results.
`timescale 1ns/1ps
module tb_iir_m_feeder;
  localparam int DIN_W = 12, DOUT_W = 18, CNT_W = 16, FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iir_m_feeder_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .CNT_W(CNT_W)) bus ();
  iir_m_feeder_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .CNT_W(CNT_W)) bus1 ();

  iir_m_feeder #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .FIFO_DEPTH(8), .FRAME_LEN(FL),
                 .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  iir_m_feeder #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .FIFO_DEPTH(8), .FRAME_LEN(1),
                 .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DIN_W-1:0]  exp_din [$];
  logic signed [DOUT_W-1:0] exp_m [$];
  bit auto_mexp = 1'b1, chk_lat = 1'b1, lat_armed = 1'b0, flt_en = 1'b1, man_req = 1'b0;
  int req_cyc = 0, req_dly = 3, gen = 0;
  logic signed [DOUT_W-1:0] man_r;

  typedef struct {
    logic [3:0][DIN_W-1:0]  smp;
    logic [3:0][DOUT_W-1:0] res;
    int                     dly;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic signed [DOUT_W-1:0] model(input logic signed [DIN_W-1:0] v);
    return DOUT_W'(int'(v) * 64);
  endfunction

  // Monitor: every issued sample and every result is checked against the queues.
  logic signed [DIN_W-1:0] mon_e;
  initial forever begin
    @(posedge clk); #1;
    if (bus.flt_din_valid) begin
      if (exp_din.size() == 0) chk("unexpected flt_din_valid", 1, 0);
      else begin
        mon_e = exp_din.pop_front();
        chk("flt_din", bus.flt_din, mon_e);
        if (auto_mexp) exp_m.push_back(model(mon_e));
      end
      if (lat_armed) begin
        if (chk_lat) chk("request->strobe latency", cyc, req_cyc + 1);
        lat_armed = 1'b0;
      end
    end
    if (bus.m_valid) begin
      if (exp_m.size() == 0) chk("unexpected m_valid", 1, 0);
      else chk("m_data", bus.m_data, exp_m.pop_front());
    end
  end

  // Emulated filter: request (with previous result) req_dly cycles after each strobe.
  logic signed [DOUT_W-1:0] em_r;
  int em_gen, em_dly;
  bit em_go;
  initial begin
    bus.flt_dout_prevalid = 1'b0; bus.flt_dout_valid = 1'b0; bus.flt_dout = '0;
    forever begin
      @(posedge clk); #1;
      em_go = 1'b0;
      if (man_req) begin
        man_req = 1'b0; em_r = man_r; em_gen = gen; em_dly = 1; em_go = 1'b1;
      end else if (bus.flt_din_valid && flt_en) begin
        em_r = model(bus.flt_din); em_gen = gen; em_dly = req_dly; em_go = 1'b1;
      end
      if (em_go) begin
        repeat (em_dly) @(negedge clk);
        if (em_gen == gen) begin
          bus.flt_dout_prevalid = 1'b1; bus.flt_dout_valid = 1'b1; bus.flt_dout = em_r;
          @(posedge clk); #1;
          bus.flt_dout_prevalid = 1'b0; bus.flt_dout_valid = 1'b0;
          req_cyc = cyc; lat_armed = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic signed [DIN_W-1:0] v);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.s_ready) chk("push wait for s_ready", 0, 1);
    else begin
      bus.s_data = v; bus.s_valid = 1'b1;
      @(posedge clk);
      exp_din.push_back(v);
      #1 bus.s_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    lat_armed = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic frame_end(input string name, input logic exp_und);
    int n = 0;
    while (!bus.done && n < 400) begin @(posedge clk); #1; n++; end
    chk({name, " done"}, bus.done, 1);
    chk({name, " busy low at done"}, bus.busy, 0);
    chk({name, " in_cnt"}, bus.in_cnt, FL);
    chk({name, " out_cnt"}, bus.out_cnt, FL);
    chk({name, " underrun"}, bus.underrun, exp_und);
    @(posedge clk); #1;
    chk({name, " done single pulse"}, bus.done, 0);
    chk({name, " results outstanding"}, exp_m.size(), 0);
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, " flt_din"}, bus.flt_din, 0);
    chk({p, " flt_din_valid"}, bus.flt_din_valid, 0);
    chk({p, " m_data"}, bus.m_data, 0);
    chk({p, " m_valid"}, bus.m_valid, 0);
    chk({p, " busy"}, bus.busy, 0);
    chk({p, " done"}, bus.done, 0);
    chk({p, " underrun"}, bus.underrun, 0);
    chk({p, " in_cnt"}, bus.in_cnt, 0);
    chk({p, " out_cnt"}, bus.out_cnt, 0);
    chk({p, " s_ready"}, bus.s_ready, 1);
  endtask

  task automatic set_row(input int i, input int a, b, c, d,
                         input int ra, rb, rc, rd, input int dly);
    tbl[i].smp[0] = DIN_W'(a);   tbl[i].smp[1] = DIN_W'(b);
    tbl[i].smp[2] = DIN_W'(c);   tbl[i].smp[3] = DIN_W'(d);
    tbl[i].res[0] = DOUT_W'(ra); tbl[i].res[1] = DOUT_W'(rb);
    tbl[i].res[2] = DOUT_W'(rc); tbl[i].res[3] = DOUT_W'(rd);
    tbl[i].dly = dly;
  endtask

  int n, cnt;
  logic signed [DIN_W-1:0] rv;

  initial begin
    bus.s_data = '0; bus.s_valid = 1'b0; bus.start = 1'b0;
    bus1.s_data = '0; bus1.s_valid = 1'b0; bus1.start = 1'b0;
    bus1.flt_dout_prevalid = 1'b0; bus1.flt_dout_valid = 1'b0; bus1.flt_dout = '0;

    set_row(0, 1, 2, 3, 4, 64, 128, 192, 256, 3);
    set_row(1, -1, 2047, -2048, 0, -64, 131008, -131072, 0, 1);
    set_row(2, 5, -5, 100, -100, 320, -320, 6400, -6400, 5);

    repeat (3) @(negedge clk);
    chk_reset_state("in reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("after reset");

    // Table-driven frames with hand-computed results.
    auto_mexp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_dly = tbl[i].dly;
      for (int j = 0; j < 4; j++) begin
        push($signed(tbl[i].smp[j]));
        exp_m.push_back($signed(tbl[i].res[j]));
      end
      pulse_start();
      frame_end($sformatf("table%0d", i), 1'b0);
    end
    auto_mexp = 1'b1;

    // Preload 1..8, stall the 9th, then two frames answered 3 cycles after each strobe.
    for (int i = 1; i <= 8; i++) push(DIN_W'(i));
    @(negedge clk);
    chk("9th push stalled", bus.s_ready, 0);
    bus.s_data = DIN_W'(9); bus.s_valid = 1'b1;
    @(posedge clk); #1 bus.s_valid = 1'b0;
    req_dly = 3;
    pulse_start();
    frame_end("preload A", 1'b0);
    pulse_start();
    frame_end("preload B", 1'b0);
    chk("preload stream consumed", exp_din.size(), 0);

    // Underrun: request hits an empty FIFO, sample arrives later.
    chk_lat = 1'b0; req_dly = 2;
    push(DIN_W'(11));
    pulse_start();
    n = 0;
    while (!bus.underrun && n < 50) begin @(posedge clk); #1; n++; end
    chk("underrun set", bus.underrun, 1);
    repeat (5) @(negedge clk);
    push(DIN_W'(-12));
    chk("no strobe at push edge", bus.flt_din_valid, 0);
    @(posedge clk); #1;
    chk("strobe one edge after push", bus.flt_din_valid, 1);
    push(DIN_W'(13));
    push(DIN_W'(-14));
    frame_end("underrun", 1'b1);
    chk_lat = 1'b1;

    // Push and pop in the same edge at depth 1, then start while busy.
    flt_en = 1'b0;
    push(DIN_W'(300));
    pulse_start();
    push(DIN_W'(-7));
    chk("prime strobe with concurrent push", bus.flt_din_valid, 1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("s_ready before fill %0d", i), bus.s_ready, 1);
      push(DIN_W'(20 + i));
    end
    chk("fifo full after overlap", bus.s_ready, 0);
    pulse_start();
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.flt_din_valid) cnt++; end
    chk("start while busy: no strobe", cnt, 0);
    chk("start while busy: busy", bus.busy, 1);
    chk("start while busy: in_cnt", bus.in_cnt, 1);
    flt_en = 1'b1;
    @(negedge clk);
    man_r = model(DIN_W'(300)); man_req = 1'b1;
    frame_end("overlap", 1'b0);

    // Reset after two samples of a frame.
    pulse_start();
    n = 0;
    while (bus.in_cnt != CNT_W'(2) && n < 100) begin @(posedge clk); #1; n++; end
    chk("reached in_cnt 2", bus.in_cnt, 2);
    flt_en = 1'b0; gen++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_din.delete(); exp_m.delete(); lat_armed = 1'b0;
    chk_reset_state("mid-frame reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("after mid-frame reset");
    @(negedge clk);
    man_r = DOUT_W'(1234); man_req = 1'b1;
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (bus.m_valid) cnt++; end
    chk("stray result ignored", cnt, 0);
    chk("stray result out_cnt", bus.out_cnt, 0);
    for (int i = 0; i < 8; i++) push(DIN_W'(40 + i));
    chk("fifo flushed by reset", bus.s_ready, 0);
    flt_en = 1'b1; req_dly = 2;
    pulse_start();
    chk("restart in_cnt", bus.in_cnt, 0);
    frame_end("restart", 1'b0);

    // Randomized frames against the queue model.
    for (int f = 0; f < 6; f++) begin
      req_dly = $urandom_range(1, 5);
      for (int j = 0; j < 4; j++) begin
        rv = DIN_W'($urandom);
        push(rv);
      end
      pulse_start();
      frame_end($sformatf("random%0d", f), 1'b0);
    end

    // FRAME_LEN = 1 instance.
    @(negedge clk); bus1.s_data = DIN_W'(7); bus1.s_valid = 1'b1;
    @(posedge clk); #1 bus1.s_valid = 1'b0;
    @(negedge clk); bus1.s_data = DIN_W'(9); bus1.s_valid = 1'b1;
    @(posedge clk); #1 bus1.s_valid = 1'b0;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus1.flt_din_valid) begin cnt++; chk("len1 flt_din", bus1.flt_din, 7); end
    end
    chk("len1 single strobe", cnt, 1);
    chk("len1 in_cnt", bus1.in_cnt, 1);
    @(negedge clk); bus1.flt_dout_prevalid = 1'b1;
    @(posedge clk); #1 bus1.flt_dout_prevalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (bus1.flt_din_valid) cnt++; end
    chk("len1 late request issues nothing", cnt, 1);
    @(negedge clk); bus1.flt_dout = DOUT_W'(448); bus1.flt_dout_valid = 1'b1;
    @(posedge clk); #1 bus1.flt_dout_valid = 1'b0;
    chk("len1 m_valid", bus1.m_valid, 1);
    chk("len1 m_data", bus1.m_data, 448);
    @(posedge clk); #1;
    chk("len1 done not yet", bus1.done, 0);
    @(posedge clk); #1;
    chk("len1 done", bus1.done, 1);
    chk("len1 busy low", bus1.busy, 0);
    chk("len1 out_cnt", bus1.out_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
